// File: rtl/subcarrier_framer.sv
// subcarrier_framer: collects 48 mapped data symbols per frame and drains a
// 64-bin frequency-domain frame (null, pilot and data bins) towards the IFFT
// loader over a valid/ready handshake.
// Optional feature macro: PILOT_EN (pilot bins carry BPSK pilots when defined,
// otherwise they are emitted as zero like null bins).
module subcarrier_framer #(
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic [5:0]           out_idx,
  output logic                 out_last
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [5:0] LAST_DATA = 6'd47;
  localparam logic [5:0] LAST_BIN  = 6'd63;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [5:0]        r_cnt;
  logic [5:0]        r_idx;
  logic [5:0]        r_rd;
  logic              r_in_ready;
  logic              w_wr;
  logic              w_fire;
  logic              w_bin_data;

  logic signed [DW-1:0] r_buf_re [0:47];
  logic signed [DW-1:0] r_buf_im [0:47];

  // Null bins: DC plus the guard band around Nyquist.
  function automatic logic bin_is_null(input logic [5:0] b);
    return (b == 6'd0) || ((b >= 6'd27) && (b <= 6'd37));
  endfunction

  function automatic logic bin_is_pilot(input logic [5:0] b);
    return (b == 6'd7) || (b == 6'd21) || (b == 6'd43) || (b == 6'd57);
  endfunction

  assign in_ready   = r_in_ready;
  assign w_wr       = (r_state == FILL) && in_valid && r_in_ready;
  assign w_fire     = (r_state == DRAIN) && out_ready;
  assign w_bin_data = !bin_is_null(r_idx) && !bin_is_pilot(r_idx);

  // Next-state selection: leave FILL on the 48th symbol, leave DRAIN on bin 63.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL:    if (w_wr && (r_cnt == LAST_DATA)) w_state_nxt = DRAIN;
      DRAIN:   if (w_fire && (r_idx == LAST_BIN)) w_state_nxt = FILL;
      default: w_state_nxt = FILL;
    endcase
  end

  // Control state: FSM, write count, bin index and buffer read pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rd       <= '0;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Ready is registered so it stays low while reset is held and rises
      // on the first edge after release.
      r_in_ready <= (w_state_nxt == FILL);
      if (w_wr) begin
        r_cnt <= (r_cnt == LAST_DATA) ? 6'd0 : r_cnt + 6'd1;
      end
      if (w_fire) begin
        r_idx <= r_idx + 6'd1;
        if (w_bin_data) begin
          r_rd <= (r_rd == LAST_DATA) ? 6'd0 : r_rd + 6'd1;
        end
      end
    end
  end

  // Symbol buffer: data bins are written in ascending order, no reset needed.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_buf_re[r_cnt] <= in_re;
      r_buf_im[r_cnt] <= in_im;
    end
  end

  // Output mux: bins are decoded from the registered index, so they hold
  // steady during stalls and collapse to zero whenever the FSM is in FILL.
  always_comb begin
    out_re    = '0;
    out_im    = '0;
    out_valid = (r_state == DRAIN);
    out_idx   = r_idx;
    out_last  = (r_state == DRAIN) && (r_idx == LAST_BIN);
    if (r_state == DRAIN) begin
      if (bin_is_pilot(r_idx)) begin
`ifdef PILOT_EN
        out_re = (r_idx == 6'd57) ? {DW{1'b1}} : DW'(1);
`else
        out_re = '0;
`endif
      end else if (!bin_is_null(r_idx)) begin
        out_re = r_buf_re[r_rd];
        out_im = r_buf_im[r_rd];
      end
    end
  end

endmodule

// File: tb/tb_subcarrier_framer.sv
// Self-checking bench for subcarrier_framer: a frame-level model builds each
// expected 64-bin frame from the queue of accepted symbols; one process
// compares every output cycle, and directed tests pin literal bin values.
module tb_subcarrier_framer;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_re = '0;
  logic signed [DW-1:0] in_im = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] out_re;
  logic signed [DW-1:0] out_im;
  logic [5:0]           out_idx;
  logic                 out_last;

  int checks = 0;
  int errors = 0;
  int n_frames = 0;
  bit rnd_mode = 1'b0;

  int qre[$];
  int qim[$];
  int m_pos = 0;
  int cap_re[64];
  int cap_im[64];
  int ref_re[64];
  int ref_im[64];
  bit prev_stall = 1'b0;
  bit last_acc = 1'b0;
  int p_re, p_im, p_idx, p_last;

  subcarrier_framer #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_is_null(input int b);
    return (b == 0) || (b >= 27 && b <= 37);
  endfunction

  function automatic bit m_is_pilot(input int b);
    return (b == 7) || (b == 21) || (b == 43) || (b == 57);
  endfunction

  // Expected content of bin b of the frame at the head of the symbol queue.
  task automatic model_bin(input int b, output int er, output int ei);
    int di;
    er = 0;
    ei = 0;
    if (m_is_pilot(b)) begin
`ifdef PILOT_EN
      er = (b == 57) ? -1 : 1;
`endif
    end else if (!m_is_null(b)) begin
      di = 0;
      for (int j = 0; j < b; j++) if (!m_is_null(j) && !m_is_pilot(j)) di++;
      if (di < qre.size()) begin
        er = qre[di];
        ei = qim[di];
      end else begin
        chk(1'b0, "model_queue_short", qre.size(), di + 1);
      end
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    int er, ei, junk;
    if (rst) begin
      chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
      chk(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
      chk(out_re == 0 && out_im == 0, "rst_out_data", int'(out_re), 0);
      chk(out_idx == 0 && out_last == 0, "rst_out_idx", int'(out_idx), 0);
      qre.delete();
      qim.delete();
      m_pos = 0;
      prev_stall = 1'b0;
      last_acc = 1'b0;
    end else begin
      chk(in_ready == !out_valid, "ready_vs_valid", int'(in_ready), int'(!out_valid));
      if (last_acc) chk(in_ready == 1'b1, "ready_after_last", int'(in_ready), 1);
      last_acc = 1'b0;
      if (prev_stall && out_valid) begin
        chk(int'(out_re) == p_re && int'(out_im) == p_im, "stall_data", int'(out_re), p_re);
        chk(int'(out_idx) == p_idx && int'(out_last) == p_last, "stall_idx", int'(out_idx), p_idx);
      end
      if (in_valid && in_ready) begin
        qre.push_back(int'(in_re));
        qim.push_back(int'(in_im));
      end
      if (out_valid) begin
        model_bin(m_pos, er, ei);
        chk(int'(out_idx) == m_pos, "out_idx", int'(out_idx), m_pos);
        chk(out_last == (m_pos == 63), "out_last", int'(out_last), int'(m_pos == 63));
        chk(int'(out_re) == er, "out_re", int'(out_re), er);
        chk(int'(out_im) == ei, "out_im", int'(out_im), ei);
        prev_stall = !out_ready;
        p_re = int'(out_re); p_im = int'(out_im);
        p_idx = int'(out_idx); p_last = int'(out_last);
        if (out_ready) begin
          cap_re[m_pos] = int'(out_re);
          cap_im[m_pos] = int'(out_im);
          if (m_pos == 63) begin
            for (int j = 0; j < 48; j++) begin
              junk = qre.pop_front();
              junk = qim.pop_front();
            end
            m_pos = 0;
            n_frames++;
            last_acc = 1'b1;
          end else begin
            m_pos++;
          end
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic feed(input int re, input int im);
    bit acc;
    in_valid = 1'b1;
    in_re = DW'(re);
    in_im = DW'(im);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk(1'b0, "feed_timeout", 0, 1);
  endtask

  task automatic wait_frames(input int target);
    for (int t = 0; t < 2000; t++) begin
      if (n_frames >= target) return;
      @(posedge clk);
      #1;
    end
    chk(1'b0, "frame_timeout", n_frames, target);
  endtask

  task automatic pin(input int b, input int er, input int ei, input string name);
    chk(cap_re[b] == er, name, cap_re[b], er);
    chk(cap_im[b] == ei, name, cap_im[b], ei);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk(in_ready == 1'b1, "ready_after_reset", int'(in_ready), 1);

    // Ramp frame, free-running drain.
    for (int k = 0; k < 48; k++) feed(k - 24, 24 - k);
    in_valid = 1'b0;
    wait_frames(1);
    pin(1, -24, 24, "bin1");
    pin(26, -1, 1, "bin26");   // 24th data bin, k=23
    pin(38, 0, 0, "bin38");    // 25th data bin, k=24
    pin(63, 23, -23, "bin63");
    pin(0, 0, 0, "bin0");
    pin(32, 0, 0, "bin32");
`ifdef PILOT_EN
    pin(7, 1, 0, "pilot7");
    pin(21, 1, 0, "pilot21");
    pin(43, 1, 0, "pilot43");
    pin(57, -1, 0, "pilot57");
`else
    pin(7, 0, 0, "pilot7");
    pin(57, 0, 0, "pilot57");
`endif
    for (int b = 0; b < 64; b++) begin
      ref_re[b] = cap_re[b];
      ref_im[b] = cap_im[b];
    end

    // Same frame under a random back-pressure pattern.
    rnd_mode = 1'b1;
    for (int k = 0; k < 48; k++) feed(k - 24, 24 - k);
    in_valid = 1'b0;
    wait_frames(2);
    rnd_mode = 1'b0;
    for (int b = 0; b < 64; b++) begin
      chk(cap_re[b] == ref_re[b] && cap_im[b] == ref_im[b], "stall_frame_match", cap_re[b], ref_re[b]);
    end

    // Reset during FILL discards the partial frame.
    for (int k = 0; k < 20; k++) feed(1000 + k, -1000 - k);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 48; k++) feed(k + 50, k - 90);
    in_valid = 1'b0;
    wait_frames(3);
    pin(1, 50, -90, "post_rst_bin1");
    pin(63, 97, -43, "post_rst_bin63");

    // Reset in the middle of DRAIN.
    for (int k = 0; k < 48; k++) feed(2 * k, k);
    in_valid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (out_valid && out_idx == 6'd29) found = 1'b1;
    end
    chk(found, "reach_idx29", int'(out_idx), 29);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk(out_valid == 1'b0, "drain_rst_valid", int'(out_valid), 0);
    chk(out_idx == 6'd0, "drain_rst_idx", int'(out_idx), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk(in_ready == 1'b1, "drain_rst_ready", int'(in_ready), 1);
    for (int k = 0; k < 48; k++) feed(-k, k + 1);
    in_valid = 1'b0;
    wait_frames(4);
    pin(1, 0, 1, "after_drain_rst_bin1");
    pin(63, -47, 48, "after_drain_rst_bin63");

    // Two back-to-back frames with in_valid held high.
    for (int k = 0; k < 96; k++) feed(k - 48, k);
    in_valid = 1'b0;
    wait_frames(6);
    pin(1, 0, 48, "b2b_bin1");
    pin(63, 47, 95, "b2b_bin63");
    chk(n_frames == 6, "frame_count", n_frames, 6);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
